gpu_host_driver: RTL and testbench

Mainboard-side initiator for the GPU controller command interface: turns host block requests (copy to GPU memory, copy from GPU memory, kernel launch) into the word-by-word `cpu_recv_instr`/`cpu_in_data` command stream and consumes `cpu_out_data`/`cpu_out_ack` responses. It sits on the mainboard CPU side of the die boundary, driving `gpu_die`'s CPU-facing ports directly. It gives the host a valid/ready request port, streaming write/read data ports, and an ack-timeout error path.

---
 rtl/gpu_ctrl_pkg.sv | 45 ++++
 rtl/gpu_host_driver_ack_timeout_timer.sv | 31 +++
 rtl/gpu_host_driver.sv | 172 +++++++++++++++++
 tb/tb_gpu_host_driver.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_ctrl_pkg.sv
// Opcodes, request kinds and driver state codes shared by the GPU controller and the host driver.
// No logic of its own; pure definitions and two small decode helpers.
package gpu_ctrl_pkg;

  localparam logic [31:0] OP_NOP           = 32'd0;
  localparam logic [31:0] OP_COPY_TO_GPU   = 32'd1;
  localparam logic [31:0] OP_COPY_FROM_GPU = 32'd2;
  localparam logic [31:0] OP_KERNEL_LAUNCH = 32'd3;
  localparam logic [31:0] OP_OPERAND       = 32'd4;

  typedef enum logic [1:0] {
    REQ_COPY_TO_GPU   = 2'd0,
    REQ_COPY_FROM_GPU = 2'd1,
    REQ_LAUNCH        = 2'd2,
    REQ_RESERVED      = 2'd3
  } req_op_e;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE       = 4'd0;
  localparam state_t ST_ISSUE_OP   = 4'd1;
  localparam state_t ST_WAIT_OP    = 4'd2;
  localparam state_t ST_ISSUE_CNT  = 4'd3;
  localparam state_t ST_WAIT_CNT   = 4'd4;
  localparam state_t ST_ISSUE_DATA = 4'd5;
  localparam state_t ST_WAIT_DATA  = 4'd6;
  localparam state_t ST_RECV_DATA  = 4'd7;
  localparam state_t ST_DONE       = 4'd8;

  function automatic logic [31:0] opcode_for(req_op_e op);
    case (op)
      REQ_COPY_TO_GPU:   return OP_COPY_TO_GPU;
      REQ_COPY_FROM_GPU: return OP_COPY_FROM_GPU;
      REQ_LAUNCH:        return OP_KERNEL_LAUNCH;
      default:           return OP_NOP;
    endcase
  endfunction

  // States in which the driver is waiting on the GPU and the ack timer runs.
  function automatic logic is_wait_state(state_t s);
    return (s == ST_WAIT_OP) || (s == ST_WAIT_CNT) ||
           (s == ST_WAIT_DATA) || (s == ST_RECV_DATA);
  endfunction

endpackage

// File: rtl/gpu_host_driver_ack_timeout_timer.sv
// Ack watchdog: counts enabled cycles, expired on the timeout_cycles-th one; held at zero when disabled.
// Latency 0 (expired is combinational from the count); no backpressure.
module ack_timeout_timer #(
  parameter int timeout_cycles = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int cnt_width = $clog2(timeout_cycles + 1);
  localparam logic [cnt_width-1:0] last_cnt = cnt_width'(timeout_cycles - 1);

  logic [cnt_width-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!enable || clear) begin
      cnt_q <= '0;
    end else if (cnt_q != last_cnt) begin
      cnt_q <= cnt_q + cnt_width'(1);
    end
  end

  // An ack in the same cycle restarts the count rather than expiring it.
  assign expired = enable && !clear && (cnt_q == last_cnt);

endmodule

// File: rtl/gpu_host_driver.sv
// Host-side initiator turning block requests into the GPU controller's issue/ack word stream.
// Accept->first issue 1 cycle, final ack->done 1 cycle; write stream stalls in ISSUE_DATA, reads have no backpressure.
module gpu_host_driver
  import gpu_ctrl_pkg::*;
#(
  parameter int data_width     = 32,
  parameter int count_width    = 16,
  parameter int timeout_cycles = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [data_width-1:0]  req_addr,
  input  logic [count_width-1:0] req_count,
  input  logic                   wr_valid,
  input  logic [data_width-1:0]  wr_data,
  output logic                   wr_ready,
  output logic                   rd_valid,
  output logic [data_width-1:0]  rd_data,
  output logic                   done,
  output logic                   err,
  output logic [31:0]            cpu_recv_instr,
  output logic [data_width-1:0]  cpu_in_data,
  input  logic [data_width-1:0]  cpu_out_data,
  input  logic                   cpu_out_ack
);

  state_t                 state_q, state_d;
  req_op_e                op_q;
  logic [data_width-1:0]  addr_q;
  logic [count_width-1:0] remaining_q;
  logic                   err_q;

  logic accept;
  logic in_wait;
  logic tmo_expired;
  logic timeout_abort;
  logic data_ack;
  logic last_word;

  assign req_ready     = (state_q == ST_IDLE) && !rst;
  assign accept        = req_valid && req_ready;
  assign in_wait       = is_wait_state(state_q);
  assign timeout_abort = tmo_expired && !cpu_out_ack;
  assign data_ack      = cpu_out_ack &&
                         ((state_q == ST_WAIT_DATA) || (state_q == ST_RECV_DATA));
  assign last_word     = (remaining_q == count_width'(1));

  ack_timeout_timer #(
    .timeout_cycles(timeout_cycles)
  ) u_ack_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (cpu_out_ack),
    .enable (in_wait),
    .expired(tmo_expired)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = (req_op_e'(req_op) == REQ_RESERVED) ? ST_DONE : ST_ISSUE_OP;
        end
      end
      ST_ISSUE_OP: state_d = ST_WAIT_OP;
      ST_WAIT_OP: begin
        if (cpu_out_ack) begin
          state_d = (op_q == REQ_LAUNCH) ? ST_DONE : ST_ISSUE_CNT;
        end else if (timeout_abort) begin
          state_d = ST_DONE;
        end
      end
      ST_ISSUE_CNT: state_d = ST_WAIT_CNT;
      ST_WAIT_CNT: begin
        if (cpu_out_ack) begin
          if (remaining_q == '0) begin
            state_d = ST_DONE;
          end else if (op_q == REQ_COPY_TO_GPU) begin
            state_d = ST_ISSUE_DATA;
          end else begin
            state_d = ST_RECV_DATA;
          end
        end else if (timeout_abort) begin
          state_d = ST_DONE;
        end
      end
      // Waiting on the host write stream is deliberately untimed.
      ST_ISSUE_DATA: begin
        if (wr_valid) begin
          state_d = ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: begin
        if (cpu_out_ack) begin
          state_d = last_word ? ST_DONE : ST_ISSUE_DATA;
        end else if (timeout_abort) begin
          state_d = ST_DONE;
        end
      end
      ST_RECV_DATA: begin
        if (cpu_out_ack) begin
          state_d = last_word ? ST_DONE : ST_RECV_DATA;
        end else if (timeout_abort) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= REQ_COPY_TO_GPU;
      addr_q      <= '0;
      remaining_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q        <= req_op_e'(req_op);
        addr_q      <= req_addr;
        remaining_q <= req_count;
      end else if (data_ack) begin
        remaining_q <= remaining_q - count_width'(1);
      end
      if (state_q == ST_DONE) begin
        err_q <= 1'b0;
      end else if (timeout_abort) begin
        err_q <= 1'b1;
      end
    end
  end

  // The word count still holds the request value when it is issued.
  always_comb begin
    cpu_recv_instr = OP_NOP;
    cpu_in_data    = '0;
    case (state_q)
      ST_ISSUE_OP: begin
        cpu_recv_instr = opcode_for(op_q);
        cpu_in_data    = addr_q;
      end
      ST_ISSUE_CNT: begin
        cpu_recv_instr = OP_OPERAND;
        cpu_in_data    = data_width'(remaining_q);
      end
      ST_ISSUE_DATA: begin
        if (wr_valid) begin
          cpu_recv_instr = OP_OPERAND;
          cpu_in_data    = wr_data;
        end
      end
      default: begin
        cpu_recv_instr = OP_NOP;
        cpu_in_data    = '0;
      end
    endcase
  end

  assign wr_ready = (state_q == ST_ISSUE_DATA);
  assign rd_valid = (state_q == ST_RECV_DATA) && cpu_out_ack;
  assign rd_data  = rd_valid ? cpu_out_data : '0;
  assign done     = (state_q == ST_DONE);
  assign err      = (state_q == ST_DONE) && err_q;

endmodule

// File: tb/tb_gpu_host_driver.sv
// Bench for gpu_host_driver: scripted and random requests against a responder and an issue-stream model.
module tb_gpu_host_driver;
  import gpu_ctrl_pkg::*;

  localparam int DW  = 32;
  localparam int CW  = 16;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [DW-1:0] req_addr;
  logic [CW-1:0] req_count;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          done;
  logic          err;
  logic [31:0]   cpu_recv_instr;
  logic [DW-1:0] cpu_in_data;
  logic [DW-1:0] cpu_out_data;
  logic          cpu_out_ack;

  gpu_host_driver #(
    .data_width(DW), .count_width(CW), .timeout_cycles(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_count(req_count),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .done(done), .err(err),
    .cpu_recv_instr(cpu_recv_instr), .cpu_in_data(cpu_in_data),
    .cpu_out_data(cpu_out_data), .cpu_out_ack(cpu_out_ack)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int tests_run = 0;
  int tests_failed = 0;

  // Responder and host write-stream state.
  int          ack_gap = 2;
  bit          resp_on = 1'b1;
  bit          stray_ack = 1'b0;
  int          cd = 0;
  logic [31:0] ack_q[$];
  logic [31:0] rd_src[$];
  logic [31:0] wr_q[$];
  logic [31:0] req_words[$];
  int          stall_pct = 0;
  logic [31:0] prev_instr = 32'd0;

  // Observation log, cleared per request.
  logic [31:0] log_instr[$];
  logic [31:0] log_data[$];
  int          log_icyc[$];
  int          log_ackcyc[$];
  logic [31:0] log_rd[$];
  int          done_n = 0;
  int          err_n = 0;
  int          viol_n = 0;
  int          wr_ready_n = 0;
  bit          outstanding = 1'b0;

  task automatic clear_log();
    log_instr.delete(); log_data.delete(); log_icyc.delete();
    log_ackcyc.delete(); log_rd.delete();
    done_n = 0; err_n = 0; viol_n = 0; wr_ready_n = 0;
  endtask

  // GPU-side responder: one ack per issue, ack_gap cycles apart; a read count issue also owes its data words.
  initial forever begin
    @(posedge clk); #1;
    cpu_out_ack  = stray_ack;
    cpu_out_data = '0;
    stray_ack    = 1'b0;
    if (ack_q.size() > 0) begin
      cd--;
      if (cd <= 0) begin
        cpu_out_ack  = 1'b1;
        cpu_out_data = ack_q.pop_front();
        cd = ack_gap;
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (wr_q.size() > 0 && $urandom_range(99, 0) >= stall_pct) begin
      wr_valid = 1'b1;
      wr_data  = wr_q[0];
    end else begin
      wr_valid = 1'b0;
      wr_data  = $urandom;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      outstanding = 1'b0;
      prev_instr  = OP_NOP;
    end else begin
      if (cpu_out_ack) begin
        outstanding = 1'b0;
        log_ackcyc.push_back(cyc);
      end
      if (cpu_recv_instr != OP_NOP) begin
        if (outstanding) viol_n++;
        outstanding = 1'b1;
        log_instr.push_back(cpu_recv_instr);
        log_data.push_back(cpu_in_data);
        log_icyc.push_back(cyc);
        if (resp_on) begin
          if (ack_q.size() == 0) cd = ack_gap;
          ack_q.push_back(32'd0);
          if (prev_instr == OP_COPY_FROM_GPU && cpu_recv_instr == OP_OPERAND) begin
            for (int i = 0; i < int'(cpu_in_data[15:0]); i++) begin
              if (rd_src.size() > 0) ack_q.push_back(rd_src.pop_front());
              else ack_q.push_back($urandom);
            end
          end
        end
        prev_instr = cpu_recv_instr;
      end
      if (rd_valid) begin
        log_rd.push_back(rd_data);
        if (!cpu_out_ack) viol_n++;
      end
      if (wr_ready) wr_ready_n++;
      if (wr_valid && wr_ready && wr_q.size() > 0) void'(wr_q.pop_front());
      if (done) done_n++;
      if (err) begin
        err_n++;
        if (!done) viol_n++;
      end
    end
  end

  task automatic send_req(input logic [1:0] op, input logic [31:0] addr, input int count,
                          output int t_acc);
    bit got = 1'b0;
    t_acc = -1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_count = CW'(count);
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin got = 1'b1; t_acc = cyc; end
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 2'($urandom); req_addr = $urandom; req_count = CW'($urandom);
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL accept: req_ready never rose within 200 cycles");
    end
  endtask

  // One error-free request; expected stream, read data and timing are derived from the request alone.
  task automatic run_request(input logic [1:0] op, input logic [31:0] addr, input int count,
                             output int t_acc, output int t_done);
    logic [31:0] exp_i[$];
    logic [31:0] exp_d[$];
    logic [31:0] exp_rd[$];
    bit got = 1'b0;
    logic ready_at_done = 1'bx;
    logic ready_after;
    clear_log();
    wr_q.delete(); rd_src.delete();
    case (op)
      2'd0: begin
        exp_i.push_back(OP_COPY_TO_GPU); exp_d.push_back(addr);
        exp_i.push_back(OP_OPERAND);     exp_d.push_back(32'(count));
        foreach (req_words[i]) begin exp_i.push_back(OP_OPERAND); exp_d.push_back(req_words[i]); end
        wr_q = req_words;
      end
      2'd1: begin
        exp_i.push_back(OP_COPY_FROM_GPU); exp_d.push_back(addr);
        exp_i.push_back(OP_OPERAND);       exp_d.push_back(32'(count));
        exp_rd = req_words;
        rd_src = req_words;
      end
      2'd2: begin
        exp_i.push_back(OP_KERNEL_LAUNCH); exp_d.push_back(addr);
      end
      default: ;
    endcase
    send_req(op, addr, count, t_acc);
    t_done = -1;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin got = 1'b1; t_done = cyc; ready_at_done = req_ready; end
    end
    @(negedge clk);
    ready_after = req_ready;
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL done_wait: op %0d no done within 2000 cycles", op);
    end
    tests_run++;
    if (log_instr.size() != exp_i.size()) begin
      tests_failed++;
      $display("FAIL issue_count: op %0d got %0d issues, want %0d", op, log_instr.size(), exp_i.size());
    end else begin
      for (int i = 0; i < exp_i.size(); i++) begin
        tests_run++;
        if (log_instr[i] !== exp_i[i] || log_data[i] !== exp_d[i]) begin
          tests_failed++;
          $display("FAIL issue[%0d]: got %0d/0x%0h, want %0d/0x%0h", i,
                   log_instr[i], log_data[i], exp_i[i], exp_d[i]);
        end
      end
    end
    tests_run++;
    if (log_rd.size() != exp_rd.size()) begin
      tests_failed++;
      $display("FAIL rd_count: got %0d reads, want %0d", log_rd.size(), exp_rd.size());
    end else begin
      for (int i = 0; i < exp_rd.size(); i++) begin
        tests_run++;
        if (log_rd[i] !== exp_rd[i]) begin
          tests_failed++;
          $display("FAIL rd[%0d]: got 0x%0h, want 0x%0h", i, log_rd[i], exp_rd[i]);
        end
      end
    end
    tests_run++;
    if (done_n != 1 || err_n != 0 || viol_n != 0) begin
      tests_failed++;
      $display("FAIL pulses: done %0d err %0d protocol_viol %0d, want 1/0/0", done_n, err_n, viol_n);
    end
    if (log_icyc.size() > 0) begin
      tests_run++;
      if (log_icyc[0] != t_acc + 1) begin
        tests_failed++;
        $display("FAIL first_issue: cycle %0d, want %0d", log_icyc[0], t_acc + 1);
      end
    end
    if (log_ackcyc.size() > 0) begin
      tests_run++;
      if (t_done != log_ackcyc[log_ackcyc.size()-1] + 1) begin
        tests_failed++;
        $display("FAIL done_timing: done at %0d, want %0d", t_done, log_ackcyc[log_ackcyc.size()-1] + 1);
      end
    end
    tests_run++;
    if (ready_at_done !== 1'b0 || ready_after !== 1'b1) begin
      tests_failed++;
      $display("FAIL ready_after_done: %b then %b, want 0 then 1", ready_at_done, ready_after);
    end
    tests_run++;
    if ((op != 2'd0 || count == 0) ? (wr_ready_n != 0) : (wr_ready_n < count)) begin
      tests_failed++;
      $display("FAIL wr_ready: asserted %0d cycles for op %0d count %0d", wr_ready_n, op, count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_op = 2'd0; req_addr = '0; req_count = '0;
    cpu_out_ack = 1'b0; cpu_out_data = '0; wr_valid = 1'b0; wr_data = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b0 || done !== 1'b0 || err !== 1'b0 || wr_ready !== 1'b0 ||
        rd_valid !== 1'b0 || rd_data !== '0 || cpu_recv_instr !== OP_NOP || cpu_in_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: ready %b done %b err %b wr_ready %b rd_valid %b instr %0d, want all 0",
               req_ready, done, err, wr_ready, rd_valid, cpu_recv_instr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL ready_after_reset: got %b want 1", req_ready);
    end
  endtask

  task automatic test_copy_to_gpu();
    int t_acc, t_done;
    ack_gap = 2; stall_pct = 0;
    req_words = '{32'hA, 32'hB, 32'hC};
    run_request(2'd0, 32'h100, 3, t_acc, t_done);
    for (int i = 0; i < 5 && i < log_icyc.size(); i++) begin
      tests_run++;
      if (log_icyc[i] != t_acc + 1 + 3 * i) begin
        tests_failed++;
        $display("FAIL copy_to_issue_cycle[%0d]: %0d want %0d", i, log_icyc[i], t_acc + 1 + 3 * i);
      end
    end
    tests_run++;
    if (t_done != t_acc + 16) begin
      tests_failed++;
      $display("FAIL copy_to_done: cycle %0d want %0d", t_done, t_acc + 16);
    end
  endtask

  task automatic test_copy_from_gpu();
    int t_acc, t_done;
    ack_gap = 2; stall_pct = 0;
    req_words = '{32'h11, 32'h22};
    run_request(2'd1, 32'h40, 2, t_acc, t_done);
    tests_run++;
    if (t_done != t_acc + 11) begin
      tests_failed++;
      $display("FAIL copy_from_done: cycle %0d want %0d", t_done, t_acc + 11);
    end
  endtask

  task automatic test_launch();
    int t_acc, t_done;
    ack_gap = 1;
    req_words.delete();
    run_request(2'd2, 32'h200, 0, t_acc, t_done);
    tests_run++;
    if (t_done != t_acc + 3) begin
      tests_failed++;
      $display("FAIL launch_done: cycle %0d want %0d", t_done, t_acc + 3);
    end
  endtask

  task automatic test_zero_count();
    int t_acc, t_done;
    ack_gap = 2;
    req_words.delete();
    run_request(2'd0, 32'h300, 0, t_acc, t_done);
    tests_run++;
    if (t_done != t_acc + 7) begin
      tests_failed++;
      $display("FAIL zero_count_done: cycle %0d want %0d", t_done, t_acc + 7);
    end
  endtask

  task automatic test_reserved_and_ignored_ack();
    int t_acc, t_done;
    int bad = 0;
    req_words.delete();
    run_request(2'd3, $urandom, 5, t_acc, t_done);
    clear_log();
    @(negedge clk);
    stray_ack = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done !== 1'b0 || req_ready !== 1'b1 || cpu_recv_instr !== OP_NOP) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL idle_ack_ignored: %0d bad idle cycles, want 0", bad);
    end
  endtask

  task automatic test_timeout();
    int t_acc;
    int t_done = -1;
    logic [31:0] pc = $urandom;
    logic err_at_done = 1'b0;
    logic ready_after;
    clear_log();
    resp_on = 1'b0;
    send_req(2'd2, pc, 0, t_acc);
    for (int i = 0; i < 100 && t_done < 0; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin t_done = cyc; err_at_done = err; end
    end
    @(negedge clk);
    ready_after = req_ready;
    resp_on = 1'b1;
    tests_run++;
    if (t_done != t_acc + 2 + TMO) begin
      tests_failed++;
      $display("FAIL timeout_done: cycle %0d want %0d", t_done, t_acc + 2 + TMO);
    end
    tests_run++;
    if (err_at_done !== 1'b1 || err_n != 1 || done_n != 1) begin
      tests_failed++;
      $display("FAIL timeout_err: err %b err_n %0d done_n %0d, want 1/1/1", err_at_done, err_n, done_n);
    end
    tests_run++;
    if (log_instr.size() != 1 || ready_after !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_after: issues %0d ready %b, want 1 issue and ready 1", log_instr.size(), ready_after);
    end
  endtask

  task automatic test_reset_mid_op();
    int t_acc, t_done;
    int late_done = 0;
    bit reached = 1'b0;
    clear_log();
    ack_gap = 6; stall_pct = 0;
    wr_q = '{32'h1, 32'h2, 32'h3, 32'h4};
    send_req(2'd0, 32'h80, 4, t_acc);
    for (int i = 0; i < 100 && !reached; i++) begin
      @(negedge clk);
      if (log_instr.size() >= 3) reached = 1'b1;
    end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    tests_run++;
    if (!reached || cpu_recv_instr !== OP_NOP || cpu_in_data !== '0 || req_ready !== 1'b0 ||
        wr_ready !== 1'b0 || done !== 1'b0 || err !== 1'b0 || rd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs: reached %b instr %0d ready %b wr_ready %b done %b",
               reached, cpu_recv_instr, req_ready, wr_ready, done);
    end
    ack_q.delete(); cd = 0; wr_q.delete();
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0) late_done++;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done !== 1'b0) late_done++;
    end
    tests_run++;
    if (late_done != 0) begin
      tests_failed++;
      $display("FAIL reset_mid_no_done: %0d done cycles, want 0", late_done);
    end
    ack_gap = 1;
    req_words.delete();
    run_request(2'd2, 32'h44, 0, t_acc, t_done);
    tests_run++;
    if (t_done != t_acc + 3) begin
      tests_failed++;
      $display("FAIL launch_after_reset: done %0d want %0d", t_done, t_acc + 3);
    end
  endtask

  task automatic test_back_to_back_random();
    int t_acc, t_done;
    for (int n = 0; n < 24; n++) begin
      logic [1:0] op = 2'($urandom_range(3, 0));
      int cnt = $urandom_range(5, 0);
      ack_gap = $urandom_range(3, 1);
      stall_pct = $urandom_range(60, 0);
      req_words.delete();
      if (op == 2'd0 || op == 2'd1) begin
        for (int i = 0; i < cnt; i++) req_words.push_back($urandom);
      end
      run_request(op, $urandom, cnt, t_acc, t_done);
    end
  endtask

  initial begin
    test_reset();
    test_copy_to_gpu();
    test_copy_from_gpu();
    test_launch();
    test_zero_count();
    test_reserved_and_ignored_ack();
    test_timeout();
    test_reset_mid_op();
    test_back_to_back_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
